// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit-side control blocks.
// Frame timing lives here so transmitter benches reuse the same figure.
package uart_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_FRAME,
    GAP
  } arb_state_t;

  // IDLE sample, start, 8 data, stop, DONE, plus one cycle of margin
  function automatic int frame_cycles(
    input int clk_freq,
    input int baud_rate
  );
    return 10 * (clk_freq / baud_rate) + 3;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side signals of the UART tx arbiter.
// The arbiter uses the slave view; client logic uses the master view.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [DATA_WIDTH-1:0]         tx_data;
  logic                          tx_start;
  logic                          busy;
  logic [IW-1:0]                 last_id;
  logic [15:0]                   frames_sent;

  modport slave (
    input  req,
    input  req_data,
    output grant,
    output tx_data,
    output tx_start,
    output busy,
    output last_id,
    output frames_sent
  );

  modport master (
    output req,
    output req_data,
    input  grant,
    input  tx_data,
    input  tx_start,
    input  busy,
    input  last_id,
    input  frames_sent
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above
// ptr, wrapping at NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic               valid_o,
  output logic [IW-1:0]      idx_o
);

  // Scan from the farthest offset down so the nearest one wins last
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        valid_o = 1'b1;
        idx_o   = IW'((int'(ptr_i) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among requesters.
// Times each frame itself since the transmitter exposes no busy flag.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int          NUM_REQ      = 4,
  parameter int          DATA_WIDTH   = 4,
  parameter int          CLK_FREQ     = 100_000_000,
  parameter int          BAUD_RATE    = 9600,
  parameter int          GAP_CYCLES   = 0,
  parameter logic [15:0] FRAMES_RESET = 16'h0000
) (
  input logic              clk,
  input logic              reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW           = $clog2(NUM_REQ);
  localparam int FRAME_CYCLES = frame_cycles(CLK_FREQ, BAUD_RATE);
  localparam int CW = $clog2(FRAME_CYCLES + GAP_CYCLES + 1);

  arb_state_t            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         win_q, win_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [15:0]           frames_q, frames_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_pick (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .valid_o(pick_valid),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      frames_q <= FRAMES_RESET;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          win_d    = pick_idx;
          data_d   = bus.req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          frames_d = frames_q + 16'd1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        ptr_d   = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
        cnt_d   = CW'(FRAME_CYCLES - 1);
        state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYCLES > 0) begin
          cnt_d   = CW'(GAP_CYCLES - 1);
          state_d = GAP;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant = '0;
    if (state_q == ISSUE) bus.grant[win_q] = 1'b1;
  end

  assign bus.tx_start    = (state_q == ISSUE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.tx_data     = data_q;
  assign bus.last_id     = win_q;
  assign bus.frames_sent = frames_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one uart_transmitter between NUM_REQ requesters. It arbitrates pending requests and drives the transmitter's data_in and transmit_en. The transmitter has no busy output, so this block times each frame itself and holds off the next issue until the line is free. It sits between client logic (sensor/status sources) and the transmitter instance in the top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 4, payload width; must match the transmitter's DATA_WIDTH
CLK_FREQ, 100_000_000, clock frequency in Hz
BAUD_RATE, 9600, line rate; BAUD_PERIOD = CLK_FREQ/BAUD_RATE
GAP_CYCLES, 0, extra idle clocks inserted between frames (0 = no gap state)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  level request per requester; hold until grant
req_data  in  NUM_REQ*DATA_WIDTH  payload; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
grant  out  NUM_REQ  one-hot, one-cycle accept pulse
tx_data  out  DATA_WIDTH  to transmitter data_in
tx_start  out  1  to transmitter transmit_en; one-cycle pulse
busy  out  1  high whenever the state is not IDLE
last_id  out  $clog2(NUM_REQ)  index of the most recently granted requester
frames_sent  out  16  count of issued frames; wraps 0xFFFF -> 0

Behaviour:
- Reset (async assert, sync deassert is the integrator's responsibility) forces these values: state IDLE, grant 0, tx_start 0, tx_data 0, busy 0, last_id 0, frames_sent 0, priority pointer 0, frame counter 0.
- Reset mid-frame abandons the frame; no grant is replayed afterwards.
- Localparam FRAME_CYCLES = 10*BAUD_PERIOD + 3. This covers the transmitter's IDLE sample, start, 8 data and stop periods, plus DONE, with 1 cycle of margin.
- States: IDLE, ISSUE, WAIT_FRAME, GAP.
- IDLE:
  - If any req bit is high, pick the first set bit scanning upward from ptr and wrapping at NUM_REQ.
  - Latch the winner's index and data; go to ISSUE.
  - Arbitration is decided in the cycle req is sampled.
- ISSUE (exactly 1 cycle):
  - grant[winner]=1, tx_start=1, tx_data=latched data.
  - last_id=winner; frames_sent+1; ptr=(winner+1) mod NUM_REQ.
  - Load the counter with FRAME_CYCLES-1; go to WAIT_FRAME.
  - Latency: req seen high at edge t gives grant/tx_start high during cycle t+1.
- tx_data holds its value until the next ISSUE.
- WAIT_FRAME:
  - Decrement the counter; at 0, go to GAP if GAP_CYCLES>0 (load GAP_CYCLES-1), else IDLE.
  - req is ignored throughout WAIT_FRAME.
- GAP: decrement; at 0, go to IDLE.
- Back-to-back: if req is still pending, the next ISSUE occurs FRAME_CYCLES+GAP_CYCLES+2 cycles after the previous ISSUE (the IDLE cycle is included).
- Requester rules:
  - Drop req in the cycle after grant is seen. A req still high after that is treated as a new request.
  - A req deasserted before its grant is a withdrawal, and is legal.
  - req_data must be stable while req is high.
- Simultaneous requests: served strictly round-robin; no requester waits more than NUM_REQ-1 frames.
- A single requester holding req continuously is granted every frame slot.
- Counter width is $clog2(FRAME_CYCLES+GAP_CYCLES+1); it never underflows.
- grant is always one-hot or zero. tx_start is never high outside ISSUE.

Decomposition:
- Package uart_ctrl_pkg holds:
  - the arb_state_t enum (IDLE, ISSUE, WAIT_FRAME, GAP);
  - function frame_cycles(clk_freq, baud_rate), which uart_transmitter testbenches also reuse.
- Sub-module rr_pick: combinational round-robin selector with inputs req and ptr, outputs valid and idx. Keep it separate for reuse and unit test.

Test Plan:
1. CLK_FREQ=1000, BAUD_RATE=100 (BAUD_PERIOD=10, FRAME_CYCLES=103), GAP_CYCLES=0. req=0001, data0=0xA at edge t -> at t+1: grant=0001, tx_start=1, tx_data=0xA; busy for 104 cycles; frames_sent=1.
2. req=1111 held with data i=i+1 -> grant order 0,1,2,3,0; tx_data sequence 1,2,3,4,1; ISSUE spacing exactly 105 cycles.
3. req0 held continuously, req2 raised mid-WAIT_FRAME -> next grant goes to 2, not 0 (ptr=1); then 0.
4. GAP_CYCLES=5 -> ISSUE spacing 110 cycles; busy stays high through GAP.
5. reset_n pulsed low mid-WAIT_FRAME -> outputs return to reset values immediately; after release, a pending req0 is granted with ptr=0.
6. frames_sent preloaded near wrap via 65536 forced grants (or a shortened-count test build) -> 0xFFFF then 0x0000; req withdrawn before grant -> no grant and no tx_start.
